ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter: MEM_TO_CYCLES, 16, cycles MEM waits for mem_ack before aborting.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port: id_comp  input  1  decoder finished; control inputs valid.
REQ-006 SHALL have port: halt, branch, memread, memwrite, regwrite  input  1 each  decoder control flags.
REQ-007 SHALL have port: PCsel  input  2  decoder PC select (2 = ALU out).
REQ-008 SHALL have port: br_taken  input  1  ALU branch compare result, valid from EXEC onward.
REQ-009 SHALL have port: mem_ack  input  1  data memory access complete.
REQ-010 SHALL have outputs, 1 bit each: ir_we (latch instruction), decode (decoder strobe), alu_en, mem_req, mem_we, reg_we, pc_we, halted, mem_err.
REQ-011 SHALL have port: pc_src  output  2  0 = PC+4, 1 = PC+imm, 2 = ALU out.
REQ-012 SHALL have port: state  output  3  current state, debug.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, DEC_WAIT, EXEC, MEM, WB, HALT.
REQ-014 IDLE -> FETCH when start=1; otherwise remain in IDLE.
REQ-015 FETCH: ir_we=1 for exactly one cycle, then DECODE.
REQ-016 DECODE: decode=1 for exactly one cycle, then DEC_WAIT.
REQ-017 DEC_WAIT: hold until id_comp=1; then HALT if halt=1, else EXEC; waiting is unbounded.
REQ-018 EXEC: alu_en=1 for one cycle; then MEM if memread|memwrite, else WB.
REQ-019 MEM: mem_req=1 and mem_we=memwrite on every MEM cycle; on mem_ack=1 -> WB; mem_ack in the first MEM cycle SHALL be accepted.
REQ-020 MEM: if MEM_TO_CYCLES cycles pass without mem_ack -> HALT with mem_err=1 (sticky).
REQ-021 WB: reg_we=regwrite, pc_we=1 for one cycle, then FETCH.
REQ-022 pc_src in WB SHALL be 1 if branch&br_taken, 0 if branch&!br_taken, 2 if !branch&PCsel==2, else 0.
REQ-023 halt=1 SHALL take priority over branch, memread and memwrite.
REQ-024 Latency: non-memory instruction = 5 cycles FETCH-to-FETCH; memory instruction with immediate ack = 6.
REQ-025 mem_ack outside MEM and id_comp outside DEC_WAIT SHALL be ignored.
REQ-026 Decoder control flags SHALL be captured when id_comp is sampled and held to WB.
REQ-027 HALT: halted=1, all strobes 0, and the block stays in HALT until rst.
REQ-028 All strobe outputs SHALL be registered, glitch-free, and 0 in every state not listed for them above.

Reset
REQ-029 rst=1 SHALL force IDLE immediately, including mid-operation; all outputs become 0, including mem_err, halted and state.
REQ-030 After rst is deasserted, the first action SHALL occur no earlier than the first clk edge with start=1.

Configuration
REQ-031 With PERF_CNT_EN defined, SHALL add outputs cycles[31:0] (increments every non-IDLE, non-HALT cycle) and instret[31:0] (increments on each WB); both wrap from 0xFFFFFFFF to 0 and clear on rst.
REQ-032 Without PERF_CNT_EN, these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the state encoding constants, the pc_src encodings (PC_PLUS4, PC_IMM, PC_ALU) and the MEM_TO_CYCLES default.
REQ-034 Counters SHALL live in one sub-module perf_cnt, instantiated only under PERF_CNT_EN.

Verification
REQ-035 ADD (regwrite=1, id_comp one cycle after decode) -> states FETCH,DECODE,DEC_WAIT,EXEC,WB; reg_we=1, pc_src=0, 5 cycles.
REQ-036 BEQ with branch=1, br_taken=1 -> pc_src=1, reg_we=0; repeat with br_taken=0 -> pc_src=0.
REQ-037 LW with memread=1, mem_ack after 3 MEM cycles -> mem_req high 3 cycles, mem_we=0, then WB with reg_we=1; SW -> mem_we=1, reg_we=0.
REQ-038 Store with mem_ack never asserted -> HALT after 16 MEM cycles, mem_err=1, halted=1.
REQ-039 ECALL with halt=1 and branch=1 -> HALT directly from DEC_WAIT, no alu_en pulse.
REQ-040 rst pulsed during MEM -> state=IDLE and all outputs 0 asynchronously; with PERF_CNT_EN, instret=0 and cycles=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - state encoding, pc_src encodings and defaults shared by the control FSM
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    DEC_WAIT = 3'd3,
    EXEC     = 3'd4,
    MEM      = 3'd5,
    WB       = 3'd6,
    HALT     = 3'd7
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam int MEM_TO_CYCLES_DEF = 16;

  // Branches override PCsel; PCsel values other than ALU fall back to PC+4.
  function automatic logic [1:0] pc_src_sel(input logic branch, input logic br_taken,
                                            input logic [1:0] pcsel);
    if (branch)
      return br_taken ? PC_IMM : PC_PLUS4;
    else if (pcsel == PC_ALU)
      return PC_ALU;
    else
      return PC_PLUS4;
  endfunction

endpackage

// File: rtl/perf_cnt.sv
// rtl/perf_cnt.sv - free-running cycle and retired-instruction counters
module perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_en,
  input  logic        ret_en,
  output logic [31:0] cycles,
  output logic [31:0] instret
);

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= 32'd0;
      instret <= 32'd0;
    end else begin
      if (cyc_en) cycles  <= cycles + 32'd1;
      if (ret_en) instret <= instret + 32'd1;
    end
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle CPU control FSM; PERF_CNT_EN adds cycles/instret counters
module ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TO_CYCLES = MEM_TO_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        id_comp,
  input  logic        halt,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic [1:0]  PCsel,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        ir_we,
  output logic        decode,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        mem_err,
  output logic [1:0]  pc_src,
  output logic [2:0]  state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycles,
  output logic [31:0] instret
`endif
);

  localparam logic [15:0] TO_LAST = 16'(MEM_TO_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        capture;

  logic        branch_q, memread_q, memwrite_q, regwrite_q;
  logic [1:0]  pcsel_q;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    capture  = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = FETCH;
      FETCH:    state_d = DECODE;
      DECODE:   state_d = DEC_WAIT;
      DEC_WAIT: begin
        if (id_comp) begin
          capture = 1'b1;
          state_d = halt ? HALT : EXEC;
        end
      end
      EXEC: begin
        to_cnt_d = 16'd0;
        state_d  = (memread_q | memwrite_q) ? MEM : WB;
      end
      // An ack on the final allowed cycle still wins over the timeout.
      MEM: begin
        if (mem_ack)
          state_d = WB;
        else if (to_cnt_q == TO_LAST)
          state_d = HALT;
        else
          to_cnt_d = to_cnt_q + 16'd1;
      end
      WB:       state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      to_cnt_q   <= 16'd0;
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      pcsel_q    <= PC_PLUS4;
      ir_we      <= 1'b0;
      decode     <= 1'b0;
      alu_en     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      reg_we     <= 1'b0;
      pc_we      <= 1'b0;
      halted     <= 1'b0;
      mem_err    <= 1'b0;
      pc_src     <= PC_PLUS4;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (capture) begin
        branch_q   <= branch;
        memread_q  <= memread;
        memwrite_q <= memwrite;
        regwrite_q <= regwrite;
        pcsel_q    <= PCsel;
      end
      ir_we   <= (state_d == FETCH);
      decode  <= (state_d == DECODE);
      alu_en  <= (state_d == EXEC);
      mem_req <= (state_d == MEM);
      mem_we  <= (state_d == MEM) && memwrite_q;
      reg_we  <= (state_d == WB) && regwrite_q;
      pc_we   <= (state_d == WB);
      halted  <= (state_d == HALT);
      mem_err <= mem_err | ((state_q == MEM) && (state_d == HALT));
      pc_src  <= (state_d == WB) ? pc_src_sel(branch_q, br_taken, pcsel_q) : PC_PLUS4;
    end
  end

  assign state = state_q;

`ifdef PERF_CNT_EN
  perf_cnt u_perf_cnt (
    .clk     (clk),
    .rst     (rst),
    .cyc_en  ((state_q != IDLE) && (state_q != HALT)),
    .ret_en  (state_q == WB),
    .cycles  (cycles),
    .instret (instret)
  );
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed self-checking bench for ctrl_fsm
module tb_ctrl_fsm;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_DEC_WAIT = 3'd3,
                         S_EXEC = 3'd4, S_MEM = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;
  localparam int TO_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, id_comp = 1'b0, halt = 1'b0, branch = 1'b0;
  logic memread = 1'b0, memwrite = 1'b0, regwrite = 1'b0;
  logic [1:0] PCsel = 2'd0;
  logic br_taken = 1'b0, mem_ack = 1'b0;
  logic ir_we, decode, alu_en, mem_req, mem_we, reg_we, pc_we, halted, mem_err;
  logic [1:0] pc_src;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycles, instret;
`endif

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .start(start), .id_comp(id_comp), .halt(halt), .branch(branch),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .PCsel(PCsel),
    .br_taken(br_taken), .mem_ack(mem_ack), .ir_we(ir_we), .decode(decode), .alu_en(alu_en),
    .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .pc_we(pc_we), .halted(halted),
    .mem_err(mem_err), .pc_src(pc_src), .state(state)
`ifdef PERF_CNT_EN
    , .cycles(cycles), .instret(instret)
`endif
  );

  logic [14:0] obs_vec;
  assign obs_vec = {state, ir_we, decode, alu_en, mem_req, mem_we, reg_we, pc_we,
                    pc_src, halted, mem_err};

  function automatic logic [14:0] exp_vec(input logic [2:0] st, input bit mw, input bit rw,
                                          input logic [1:0] ps, input bit err);
    return {st, st == S_FETCH, st == S_DECODE, st == S_EXEC, st == S_MEM,
            (st == S_MEM) && mw, (st == S_WB) && rw, st == S_WB,
            (st == S_WB) ? ps : 2'd0, st == S_HALT, err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic [2:0] st, input bit mw, input bit rw,
                         input logic [1:0] ps, input bit err);
    @(negedge clk);
    check(tag, {17'd0, obs_vec}, {17'd0, exp_vec(st, mw, rw, ps, err)});
  endtask

  task automatic clear_flags();
    id_comp = 0; halt = 0; branch = 0; memread = 0; memwrite = 0; regwrite = 0; PCsel = 2'd0;
  endtask

  // Entered with FETCH just observed; ack = MEM cycle carrying mem_ack, 0 = never.
  task automatic instr(input string tag, input bit rw, input bit mr, input bit mw, input bit br,
                       input bit brt, input logic [1:0] pcs, input bit hl, input int waits,
                       input int ack, input logic [1:0] ps);
    exp_cyc({tag, "/decode"}, S_DECODE, 0, 0, 0, 0);
    if (waits > 0) begin
      id_comp = 1; mem_ack = 1;
    end
    exp_cyc({tag, "/decwait"}, S_DEC_WAIT, 0, 0, 0, 0);
    id_comp = 0; mem_ack = 0;
    repeat (waits) exp_cyc({tag, "/decwait_hold"}, S_DEC_WAIT, 0, 0, 0, 0);
    id_comp = 1; regwrite = rw; memread = mr; memwrite = mw; branch = br; PCsel = pcs; halt = hl;
    if (hl) begin
      exp_cyc({tag, "/halt"}, S_HALT, 0, 0, 0, 0);
      clear_flags();
    end else begin
      exp_cyc({tag, "/exec"}, S_EXEC, 0, 0, 0, 0);
      clear_flags();
      br_taken = brt;
      if (mr | mw) begin
        for (int k = 1; k <= ((ack == 0) ? TO_CYC : ack); k++) begin
          exp_cyc({tag, "/mem"}, S_MEM, mw, 0, 0, 0);
          mem_ack = (k == ack);
        end
      end
      if ((mr | mw) && ack == 0) begin
        exp_cyc({tag, "/timeout"}, S_HALT, 0, 0, 0, 1);
      end else begin
        exp_cyc({tag, "/wb"}, S_WB, 0, rw, ps, 0);
        mem_ack = 0; br_taken = 0;
        exp_cyc({tag, "/next_fetch"}, S_FETCH, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; mem_ack = 0; br_taken = 0; clear_flags();
    @(negedge clk);
    check("reset_outputs", {17'd0, obs_vec}, 32'd0);
    rst = 0;
  endtask

  task automatic kick();
    start = 1;
    exp_cyc("start_fetch", S_FETCH, 0, 0, 0, 0);
    start = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {17'd0, obs_vec}, 32'd0);
    rst = 0;
    id_comp = 1; mem_ack = 1;
    exp_cyc("idle_hold", S_IDLE, 0, 0, 0, 0);
    exp_cyc("idle_hold2", S_IDLE, 0, 0, 0, 0);
    id_comp = 0; mem_ack = 0;
    kick();

    instr("add", 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0);
`ifdef PERF_CNT_EN
    check("cycles_after_add", cycles, 32'd5);
    check("instret_after_add", instret, 32'd1);
`endif
    instr("beq_taken", 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 2'd1);
    instr("beq_not_taken", 0, 0, 0, 1, 0, 2'd2, 0, 2, 0, 2'd0);
    instr("jalr", 1, 0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd2);
    instr("lw_ack3", 1, 1, 0, 0, 0, 2'd0, 0, 0, 3, 2'd0);
    instr("lw_ack1", 1, 1, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0);
    instr("sw_ack2", 0, 0, 1, 0, 0, 2'd0, 0, 1, 2, 2'd0);
    instr("sw_timeout", 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0);
    start = 1; mem_ack = 1;
    exp_cyc("halt_sticky", S_HALT, 0, 0, 0, 1);
    exp_cyc("halt_sticky2", S_HALT, 0, 0, 0, 1);
    start = 0; mem_ack = 0;

    do_reset();
    kick();
    instr("ecall", 0, 0, 1, 1, 1, 2'd0, 1, 0, 0, 2'd0);
    exp_cyc("ecall_stays", S_HALT, 0, 0, 0, 0);

    do_reset();
    kick();
    exp_cyc("rst_mem/decode", S_DECODE, 0, 0, 0, 0);
    exp_cyc("rst_mem/decwait", S_DEC_WAIT, 0, 0, 0, 0);
    id_comp = 1; memwrite = 1;
    exp_cyc("rst_mem/exec", S_EXEC, 0, 0, 0, 0);
    clear_flags();
    exp_cyc("rst_mem/mem", S_MEM, 1, 0, 0, 0);
    #2 rst = 1;
    #1 check("async_rst_outputs", {17'd0, obs_vec}, 32'd0);
`ifdef PERF_CNT_EN
    check("async_rst_cycles", cycles, 32'd0);
    check("async_rst_instret", instret, 32'd0);
`endif
    @(negedge clk);
    rst = 0;
    exp_cyc("post_rst_idle", S_IDLE, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
